sr_cmd_conditioner: RTL and testbench



---
 rtl/sr_cmd_conditioner.sv | 129 ++++++++++++
 tb/tb_sr_cmd_conditioner.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_conditioner.sv
// Turns two raw push buttons into clean, ordered S/R/E command pulses for a gated SR flip-flop.
// Each button is synchronised and debounced, and a press starts a setup/strobe/hold sequence.
module sr_cmd_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 20,
   parameter int PULSE_LEN       = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       set_btn,
   input  logic       reset_btn,
   output logic       s_out,
   output logic       r_out,
   output logic       e_out,
   output logic       busy,
   output logic       conflict,
   output logic [7:0] cmd_count
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SETUP = 2'd1;
   localparam logic [1:0] DRIVE = 2'd2;
   localparam logic [1:0] HOLD  = 2'd3;

   localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
   localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PW-1:0]    PULSE_LAST = PW'(PULSE_LEN - 1);

   // Channel 0 is the set button, channel 1 the reset button.
   logic [1:0]       w_btn;
   logic [1:0]       r_sync1;
   logic [1:0]       r_sync2;
   logic [CNT_W-1:0] r_dbCnt [2];
   logic [1:0]       r_stable;
   logic [1:0]       r_stablePrev;
   logic [1:0]       w_evt;

   logic [1:0]       r_state;
   logic             r_cmd;
   logic [PW-1:0]    r_pulseCnt;

   logic [1:0]       w_stateNext;
   logic             w_cmdNext;
   logic [PW-1:0]    w_pulseNext;
   logic             w_accept;
   logic             w_conflict;

   assign w_btn = {reset_btn, set_btn};
   assign w_evt = r_stable & ~r_stablePrev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1      <= '0;
         r_sync2      <= '0;
         r_stable     <= '0;
         r_stablePrev <= '0;
         for (int c = 0; c < 2; c++) r_dbCnt[c] <= '0;
      end else begin
         r_sync1      <= w_btn;
         r_sync2      <= r_sync1;
         r_stablePrev <= r_stable;
         // A new level is only accepted after it has differed from the stable one for DEBOUNCE_CYCLES edges.
         for (int c = 0; c < 2; c++) begin
            if (r_sync2[c] == r_stable[c]) begin
               r_dbCnt[c] <= '0;
            end else if (r_dbCnt[c] == DB_LAST) begin
               r_stable[c] <= r_sync2[c];
               r_dbCnt[c]  <= '0;
            end else begin
               r_dbCnt[c] <= r_dbCnt[c] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_cmdNext   = r_cmd;
      w_pulseNext = r_pulseCnt;
      w_accept    = 1'b0;
      w_conflict  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_evt[0] && w_evt[1]) begin
               w_conflict = 1'b1;
            end else if (w_evt[0] || w_evt[1]) begin
               w_cmdNext   = w_evt[1];
               w_stateNext = SETUP;
               w_accept    = 1'b1;
            end
         end
         SETUP: begin
            w_stateNext = DRIVE;
            w_pulseNext = '0;
         end
         DRIVE: begin
            if (r_pulseCnt == PULSE_LAST) w_stateNext = HOLD;
            else                          w_pulseNext = r_pulseCnt + 1'b1;
         end
         default: w_stateNext = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state register itself.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cmd      <= 1'b0;
         r_pulseCnt <= '0;
         s_out      <= 1'b0;
         r_out      <= 1'b0;
         e_out      <= 1'b0;
         busy       <= 1'b0;
         conflict   <= 1'b0;
         cmd_count  <= '0;
      end else begin
         r_state    <= w_stateNext;
         r_cmd      <= w_cmdNext;
         r_pulseCnt <= w_pulseNext;
         s_out      <= (w_stateNext != IDLE) && !w_cmdNext;
         r_out      <= (w_stateNext != IDLE) && w_cmdNext;
         e_out      <= (w_stateNext == DRIVE);
         busy       <= (w_stateNext != IDLE);
         conflict   <= w_conflict;
         if (w_accept) cmd_count <= cmd_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Bench for sr_cmd_conditioner: directed scenarios with literal expectations, then random button
// activity, all checked every cycle against a timeline-based behavioural model.
module tb_sr_cmd_conditioner;

   localparam int D = 4;
   localparam int P = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       set_btn = 1'b0;
   logic       reset_btn = 1'b0;
   logic       s_out, r_out, e_out, busy, conflict;
   logic [7:0] cmd_count;

   int total = 0;
   int bad = 0;

   sr_cmd_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(20), .PULSE_LEN(P)) dut (
      .clk(clk), .rst(rst), .set_btn(set_btn), .reset_btn(reset_btn),
      .s_out(s_out), .r_out(r_out), .e_out(e_out), .busy(busy),
      .conflict(conflict), .cmd_count(cmd_count)
   );

   always #10 clk = ~clk;

   // Behavioural model: buttons pass a two-edge delay, a level is adopted after D consecutive
   // differing samples, and an accepted command is a timeline of P+2 busy cycles.
   bit       mSync1 [2];
   bit       mSync2 [2];
   bit       mStable [2];
   bit       mPrev [2];
   int       mRun [2];
   int       mPhase = -1;
   bit       mCmdR = 1'b0;
   bit       mConf = 1'b0;
   bit [7:0] mCount = 8'd0;

   always @(posedge clk or posedge rst) begin
      bit ev [2];
      bit btn [2];
      if (rst) begin
         for (int c = 0; c < 2; c++) begin
            mSync1[c] = 0; mSync2[c] = 0; mStable[c] = 0; mPrev[c] = 0; mRun[c] = 0;
         end
         mPhase = -1; mCmdR = 0; mConf = 0; mCount = 0;
      end else begin
         btn[0] = set_btn;
         btn[1] = reset_btn;
         for (int c = 0; c < 2; c++) begin
            ev[c] = mStable[c] && !mPrev[c];
            mPrev[c] = mStable[c];
            if (mSync2[c] != mStable[c]) begin
               mRun[c]++;
               if (mRun[c] == D) begin
                  mStable[c] = mSync2[c];
                  mRun[c] = 0;
               end
            end else begin
               mRun[c] = 0;
            end
            mSync2[c] = mSync1[c];
            mSync1[c] = btn[c];
         end
         mConf = 0;
         if (mPhase >= 0) begin
            mPhase++;
            if (mPhase == P + 2) mPhase = -1;
         end else if (ev[0] && ev[1]) begin
            mConf = 1;
         end else if (ev[0] || ev[1]) begin
            mPhase = 0;
            mCmdR = ev[1];
            mCount++;
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Edge counter and output tallies used by the directed timing checks.
   int edgeCnt = 0;
   int sHigh = 0, rHigh = 0, eHigh = 0, busyHigh = 0, confHigh = 0;
   int lastSRise = 0, lastSFall = 0, lastERise = 0, lastEFall = 0;
   bit prevS = 0, prevE = 0;

   always @(posedge clk) edgeCnt++;

   always @(negedge clk) begin
      bit expS, expR, expE, expB;
      expB = (mPhase >= 0);
      expS = expB && !mCmdR;
      expR = expB && mCmdR;
      expE = (mPhase >= 1) && (mPhase <= P);
      checkOutput("s_out", int'(s_out), int'(expS));
      checkOutput("r_out", int'(r_out), int'(expR));
      checkOutput("e_out", int'(e_out), int'(expE));
      checkOutput("busy", int'(busy), int'(expB));
      checkOutput("conflict", int'(conflict), int'(mConf));
      checkOutput("cmd_count", int'(cmd_count), int'(mCount));
      if (s_out) sHigh++;
      if (r_out) rHigh++;
      if (e_out) eHigh++;
      if (busy) busyHigh++;
      if (conflict) confHigh++;
      if (s_out && !prevS) lastSRise = edgeCnt;
      if (!s_out && prevS) lastSFall = edgeCnt;
      if (e_out && !prevE) lastERise = edgeCnt;
      if (!e_out && prevE) lastEFall = edgeCnt;
      prevS = s_out;
      prevE = e_out;
   end

   task automatic waitEdges(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input bit setV, input bit rstV, input int cycles);
      set_btn = setV;
      reset_btn = rstV;
      waitEdges(cycles);
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      waitEdges(2);
      rst = 1'b0;
      waitEdges(2);
   endtask

   initial begin
      int start, s0, r0, e0, b0, c0, n;
      waitEdges(2);
      checkOutput("reset cmd_count", int'(cmd_count), 0);
      checkOutput("reset busy", int'(busy), 0);
      rst = 1'b0;
      waitEdges(3);

      // Set press: timing of the whole command relative to the first sampling edge.
      start = edgeCnt; s0 = sHigh; r0 = rHigh; e0 = eHigh; b0 = busyHigh;
      applyStimulus(1, 0, 15);
      applyStimulus(0, 0, 12);
      checkOutput("set s rise edge", lastSRise - start, 7);
      checkOutput("set e rise edge", lastERise - start, 8);
      checkOutput("set e fall edge", lastEFall - start, 10);
      checkOutput("set s fall edge", lastSFall - start, 11);
      checkOutput("set e cycles", eHigh - e0, 2);
      checkOutput("set busy cycles", busyHigh - b0, 4);
      checkOutput("set r cycles", rHigh - r0, 0);
      checkOutput("set s cycles", sHigh - s0, 4);
      checkOutput("set count", int'(cmd_count), 1);

      // Reset press mirrors the set case; its release must not produce another command.
      start = edgeCnt; s0 = sHigh; r0 = rHigh; e0 = eHigh; b0 = busyHigh;
      applyStimulus(0, 1, 15);
      applyStimulus(0, 0, 12);
      checkOutput("rst e rise edge", lastERise - start, 8);
      checkOutput("rst r cycles", rHigh - r0, 4);
      checkOutput("rst s cycles", sHigh - s0, 0);
      checkOutput("rst e cycles", eHigh - e0, 2);
      checkOutput("rst busy cycles", busyHigh - b0, 4);
      checkOutput("rst count", int'(cmd_count), 2);

      // Short glitch is filtered.
      b0 = busyHigh;
      applyStimulus(1, 0, 2);
      applyStimulus(0, 0, 12);
      checkOutput("glitch busy cycles", busyHigh - b0, 0);
      checkOutput("glitch count", int'(cmd_count), 2);

      // Simultaneous presses.
      s0 = sHigh; r0 = rHigh; e0 = eHigh; c0 = confHigh;
      applyStimulus(1, 1, 15);
      applyStimulus(0, 0, 12);
      checkOutput("conflict cycles", confHigh - c0, 1);
      checkOutput("conflict s+r+e", (sHigh - s0) + (rHigh - r0) + (eHigh - e0), 0);
      checkOutput("conflict count", int'(cmd_count), 2);

      // Reset press two cycles after set is dropped while busy.
      s0 = sHigh; r0 = rHigh;
      applyStimulus(1, 0, 2);
      applyStimulus(1, 1, 15);
      applyStimulus(0, 0, 12);
      checkOutput("overlap s cycles", sHigh - s0, 4);
      checkOutput("overlap r cycles", rHigh - r0, 0);
      checkOutput("overlap count", int'(cmd_count), 3);

      // Reset during the strobe, button still held afterwards.
      set_btn = 1'b1;
      n = 0;
      while (!e_out && n < 30) begin
         waitEdges(1);
         n++;
      end
      checkOutput("strobe reached", int'(e_out), 1);
      rst = 1'b1;
      #1;
      checkOutput("async e_out", int'(e_out), 0);
      checkOutput("async s_out", int'(s_out), 0);
      checkOutput("async count", int'(cmd_count), 0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      start = edgeCnt;
      applyStimulus(1, 0, 15);
      checkOutput("rerun s rise edge", lastSRise - start, 7);
      checkOutput("rerun count", int'(cmd_count), 1);
      applyStimulus(0, 0, 12);

      // Counter wrap after 257 commands.
      pulseReset();
      for (int i = 0; i < 257; i++) begin
         applyStimulus(i[0] == 1'b0, i[0] == 1'b1, 10);
         applyStimulus(0, 0, 10);
      end
      checkOutput("wrap count", int'(cmd_count), 1);

      // Random button activity with occasional resets.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            rst = 1'b1;
            waitEdges($urandom_range(1, 2));
            rst = 1'b0;
         end
         applyStimulus(1'($urandom), 1'($urandom), $urandom_range(1, 10));
      end
      applyStimulus(0, 0, 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
